// File: rtl/sine_rom_streamer.sv
// rtl/sine_rom_streamer.sv - sine ROM phase accumulator and framed serial DAC streamer
// Fetches one ROM word per accepted tick and shifts it out on cs_n/sclk/sdo.
module sine_rom_streamer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 2,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] step,
  input  logic                  clear_ovr,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  sclk,
  output logic                  sdo,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] phase;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_word;
  logic [DATA_WIDTH-1:0] ordered;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic                  div_hit;

  assign rom_addr = phase;
  assign div_hit  = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Frame word is always sent from its MSB; bit order is fixed up here.
  always_comb begin
    ordered = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ordered[i] = (MSB_FIRST != 0) ? rom_data[i] : rom_data[DATA_WIDTH-1-i];
    end
    frame_word = '0;
    frame_word[FRAME_BITS-1 -: DATA_WIDTH] = ordered;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      sclk       <= 1'b0;
      sdo        <= 1'b0;
      cs_n       <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (tick && enable && state != IDLE) begin
        overrun <= 1'b1;
      end else if (clear_ovr) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (tick && enable) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shreg   <= frame_word << 1;
          sdo     <= frame_word[FRAME_BITS-1];
          cs_n    <= 1'b0;
          sclk    <= 1'b0;
          phase   <= phase + step;
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (!div_hit) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk    <= 1'b1;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end else if (bit_cnt == BIT_W'(FRAME_BITS)) begin
              // Falling point after the last rising edge closes the frame.
              sclk       <= 1'b0;
              sdo        <= 1'b0;
              cs_n       <= 1'b1;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              bit_cnt    <= '0;
              state      <= IDLE;
            end else begin
              sclk  <= 1'b0;
              sdo   <= shreg[FRAME_BITS-1];
              shreg <= shreg << 1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_rom_streamer.sv
// tb/tb_sine_rom_streamer.sv - directed self-checking bench for sine_rom_streamer
module tb_sine_rom_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tick_a = 1'b0, enable = 1'b1, clear_ovr = 1'b0;
  logic [7:0] step = 8'd1;
  logic [7:0] rom_addr_a, rom_data_a;
  logic       sclk_a, sdo_a, cs_n_a, busy_a, frame_done_a, overrun_a;

  logic       tick_b = 1'b0;
  logic [7:0] rom_addr_b, rom_data_b;
  logic       sclk_b, sdo_b, cs_n_b, busy_b, frame_done_b, overrun_b;

  int n_checks = 0;
  int n_errors = 0;

  sine_rom_streamer dut_a (
    .clk(clk), .rst(rst), .tick(tick_a), .enable(enable), .step(step),
    .clear_ovr(clear_ovr), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .sclk(sclk_a), .sdo(sdo_a), .cs_n(cs_n_a), .busy(busy_a),
    .frame_done(frame_done_a), .overrun(overrun_a)
  );

  sine_rom_streamer #(.FRAME_BITS(8), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .tick(tick_b), .enable(enable), .step(step),
    .clear_ovr(clear_ovr), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .sclk(sclk_b), .sdo(sdo_b), .cs_n(cs_n_b), .busy(busy_b),
    .frame_done(frame_done_b), .overrun(overrun_b)
  );

  function automatic logic [7:0] rom_val(input logic [7:0] a);
    return (a == 8'h00) ? 8'h0F : (a ^ 8'h5A);
  endfunction

  always @(posedge clk) begin
    rom_data_a <= rom_val(rom_addr_a);
    rom_data_b <= rom_val(rom_addr_b);
  end

  logic [15:0] word_a = '0;
  logic [7:0]  word_b = '0;
  int nbits_a = 0, nbits_b = 0, cslow_a = 0, cslow_b = 0, fd_a = 0, fd_b = 0;

  always @(posedge sclk_a) begin
    word_a = {word_a[14:0], sdo_a};
    nbits_a++;
  end
  always @(posedge sclk_b) begin
    word_b = {word_b[6:0], sdo_b};
    nbits_b++;
  end
  always begin
    @(posedge clk);
    #1;
    if (cs_n_a === 1'b0) cslow_a++;
    if (cs_n_b === 1'b0) cslow_b++;
    if (frame_done_a === 1'b1) fd_a++;
    if (frame_done_b === 1'b1) fd_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    word_a = '0; word_b = '0;
    nbits_a = 0; nbits_b = 0; cslow_a = 0; cslow_b = 0; fd_a = 0; fd_b = 0;
  endtask

  task automatic pulse_tick_a();
    tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done_a(input string tag);
    int t = 0;
    while (frame_done_a !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'd0, frame_done_a}, 32'd1);
    @(negedge clk);
  endtask

  logic [7:0]  exp_addr [5] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};
  logic [15:0] exp_word [5] = '{16'h0F00, 16'h1A00, 16'hDA00, 16'h9A00, 16'h0F00};

  initial begin
    logic bad;
    int t;

    // 1: reset values and idle stability
    repeat (3) @(negedge clk);
    check("rst_cs_n", {31'd0, cs_n_a}, 32'd1);
    check("rst_sclk", {31'd0, sclk_a}, 32'd0);
    check("rst_sdo", {31'd0, sdo_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_overrun", {31'd0, overrun_a}, 32'd0);
    check("rst_rom_addr", {24'd0, rom_addr_a}, 32'd0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if ({cs_n_a, sclk_a, sdo_a, busy_a, frame_done_a, overrun_a} !== 6'b100000 ||
          rom_addr_a !== 8'h00 || cs_n_b !== 1'b1)
        bad = 1'b1;
    end
    check("idle_stable", {31'd0, bad}, 32'd0);

    // 2: single default frame with exact start latency
    clr_mon();
    step = 8'd1;
    pulse_tick_a();
    check("fetch_busy", {31'd0, busy_a}, 32'd1);
    check("fetch_cs_n", {31'd0, cs_n_a}, 32'd1);
    @(negedge clk);
    check("load_cs_n", {31'd0, cs_n_a}, 32'd1);
    check("load_addr", {24'd0, rom_addr_a}, 32'd0);
    @(negedge clk);
    check("shift_cs_n", {31'd0, cs_n_a}, 32'd0);
    check("shift_sclk", {31'd0, sclk_a}, 32'd0);
    check("shift_addr", {24'd0, rom_addr_a}, 32'd1);
    wait_done_a("f1_done");
    check("f1_word", {16'd0, word_a}, 32'h0F00);
    check("f1_nbits", nbits_a, 32'd16);
    check("f1_cslow", cslow_a, 32'd64);
    check("f1_fd_cycles", fd_a, 32'd1);
    check("f1_busy", {31'd0, busy_a}, 32'd0);
    check("f1_rom_addr", {24'd0, rom_addr_a}, 32'd1);

    // 3: phase wrap with step 0x40
    do_reset();
    step = 8'h40;
    for (int i = 0; i < 5; i++) begin
      clr_mon();
      check($sformatf("wrap_addr%0d", i), {24'd0, rom_addr_a}, {24'd0, exp_addr[i]});
      pulse_tick_a();
      wait_done_a($sformatf("wrap_done%0d", i));
      check($sformatf("wrap_word%0d", i), {16'd0, word_a}, {16'd0, exp_word[i]});
      repeat (930) @(negedge clk);
    end
    check("wrap_overrun", {31'd0, overrun_a}, 32'd0);

    // 4: overrun set, clear, frame-ending edge, set-beats-clear
    do_reset();
    step = 8'd1;
    clr_mon();
    pulse_tick_a();
    repeat (29) @(negedge clk);
    pulse_tick_a();
    wait_done_a("ovr_done");
    repeat (80) @(negedge clk);
    check("ovr_frames", fd_a, 32'd1);
    check("ovr_nbits", nbits_a, 32'd16);
    check("ovr_set", {31'd0, overrun_a}, 32'd1);
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    check("ovr_clear", {31'd0, overrun_a}, 32'd0);

    pulse_tick_a();
    repeat (65) @(negedge clk);
    tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0;
    check("end_edge_ovr", {31'd0, overrun_a}, 32'd1);
    check("end_edge_fd", {31'd0, frame_done_a}, 32'd1);
    check("end_edge_busy", {31'd0, busy_a}, 32'd0);
    pulse_tick_a();
    check("reaccept_busy", {31'd0, busy_a}, 32'd1);
    repeat (20) @(negedge clk);
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    check("ovr_clear2", {31'd0, overrun_a}, 32'd0);
    repeat (5) @(negedge clk);
    clear_ovr = 1'b1;
    tick_a = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    tick_a = 1'b0;
    check("set_wins", {31'd0, overrun_a}, 32'd1);
    wait_done_a("ovr_done2");

    // 5: LSB-first, CLK_DIV=1, 8-bit frame instance
    do_reset();
    clr_mon();
    tick_b = 1'b1;
    @(negedge clk);
    tick_b = 1'b0;
    t = 0;
    while (frame_done_b !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("b_done", {31'd0, frame_done_b}, 32'd1);
    @(negedge clk);
    check("b_word", {24'd0, word_b}, 32'hF0);
    check("b_nbits", nbits_b, 32'd8);
    check("b_cslow", cslow_b, 32'd16);
    check("b_rom_addr", {24'd0, rom_addr_b}, 32'd1);

    // 6: disable mid-frame, then asynchronous reset mid-frame
    do_reset();
    clr_mon();
    pulse_tick_a();
    repeat (10) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    pulse_tick_a();
    wait_done_a("dis_done");
    check("dis_word", {16'd0, word_a}, 32'h0F00);
    check("dis_nbits", nbits_a, 32'd16);
    pulse_tick_a();
    repeat (3) @(negedge clk);
    check("dis_busy", {31'd0, busy_a}, 32'd0);
    check("dis_overrun", {31'd0, overrun_a}, 32'd0);
    check("dis_rom_addr", {24'd0, rom_addr_a}, 32'd1);
    enable = 1'b1;
    pulse_tick_a();
    repeat (22) @(negedge clk);
    check("mid_cs_n", {31'd0, cs_n_a}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cs_n", {31'd0, cs_n_a}, 32'd1);
    check("arst_sclk", {31'd0, sclk_a}, 32'd0);
    check("arst_sdo", {31'd0, sdo_a}, 32'd0);
    check("arst_busy", {31'd0, busy_a}, 32'd0);
    check("arst_fd", {31'd0, frame_done_a}, 32'd0);
    check("arst_rom_addr", {24'd0, rom_addr_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clr_mon();
    pulse_tick_a();
    wait_done_a("post_rst_done");
    check("post_rst_word", {16'd0, word_a}, 32'h0F00);
    check("post_rst_nbits", nbits_a, 32'd16);
    check("post_rst_addr", {24'd0, rom_addr_a}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
